// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM-subset datapath (master) and its
// control FSM (slave): instruction fields and flags in, selects and strobes out.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic       LinkWrite;
  logic [3:0] State;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, LinkWrite, State
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, LinkWrite, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM with NZCV flags and condition evaluation.
// Optional macro CTRL_BL_EN adds the LINK state so BL writes the return address to R14.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                         CLK,
  input  logic                         nReset,
  multicycle_controller_if.slave       bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_LINK     = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cmd_s;
  logic [1:0] dp_ctrl_s;
  logic       dp_ok_s, dp_arith_s, dp_cmp_s;
  logic       cond_ex_s;
  logic       n_s, z_s, c_s, v_s;

  assign cmd_s = bus.Funct[4:1];
  assign {n_s, z_s, c_s, v_s} = flags_q;

  // Data-processing command decode: ALU operation and which side effects apply.
  always_comb begin
    dp_ctrl_s  = 2'b00;
    dp_ok_s    = 1'b1;
    dp_arith_s = 1'b0;
    dp_cmp_s   = 1'b0;
    case (cmd_s)
      4'b0100: begin dp_ctrl_s = 2'b00; dp_arith_s = 1'b1; end
      4'b0010: begin dp_ctrl_s = 2'b01; dp_arith_s = 1'b1; end
      4'b0000: dp_ctrl_s = 2'b10;
      4'b1100: dp_ctrl_s = 2'b11;
      4'b1010: begin dp_ctrl_s = 2'b01; dp_arith_s = 1'b1; dp_cmp_s = 1'b1; end
      default: dp_ok_s = 1'b0;
    endcase
  end

  // Condition check against the registered flags only.
  always_comb begin
    case (bus.Cond)
      4'b0000: cond_ex_s = z_s;
      4'b0001: cond_ex_s = !z_s;
      4'b0010: cond_ex_s = c_s;
      4'b0011: cond_ex_s = !c_s;
      4'b0100: cond_ex_s = n_s;
      4'b0101: cond_ex_s = !n_s;
      4'b0110: cond_ex_s = v_s;
      4'b0111: cond_ex_s = !v_s;
      4'b1000: cond_ex_s = c_s && !z_s;
      4'b1001: cond_ex_s = !c_s || z_s;
      4'b1010: cond_ex_s = (n_s == v_s);
      4'b1011: cond_ex_s = (n_s != v_s);
      4'b1100: cond_ex_s = !z_s && (n_s == v_s);
      4'b1101: cond_ex_s = z_s || (n_s != v_s);
      4'b1110: cond_ex_s = 1'b1;
      default: cond_ex_s = 1'b0;
    endcase
  end

  // Next state and flag update; illegal encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    flags_d = flags_q;
    case (state_q)
      S_FETCH:    state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!cond_ex_s) begin
          state_d = S_FETCH;
        end else begin
          case (bus.Op)
            2'b01:   state_d = S_MEMADR;
            2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
`ifdef CTRL_BL_EN
            2'b10:   state_d = bus.Funct[4] ? S_LINK : S_BRANCH;
`else
            2'b10:   state_d = S_BRANCH;
`endif
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = bus.MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = bus.MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI: begin
        state_d = S_ALUWB;
        // AND/ORR leave C and V untouched.
        if (dp_ok_s && (bus.Funct[0] || dp_cmp_s)) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (dp_arith_s) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
          end else begin
            flags_d[1:0] = flags_q[1:0];
          end
        end else begin
          flags_d = flags_q;
        end
      end
`ifdef CTRL_BL_EN
      S_LINK:     state_d = S_BRANCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // State and flag registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      state_q <= state_e'(RESET_STATE);
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s, link_write_s;
  logic       adr_src_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, result_src_s, imm_src_s, reg_src_s, alu_control_s;

  // Output decode per state; reset masks every write strobe immediately.
  always_comb begin
    pc_write_s    = 1'b0;
    ir_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    mem_write_s   = 1'b0;
    link_write_s  = 1'b0;
    adr_src_s     = 1'b0;
    alu_src_a_s   = 1'b0;
    alu_src_b_s   = 2'b00;
    result_src_s  = 2'b00;
    imm_src_s     = 2'b00;
    reg_src_s     = 2'b00;
    alu_control_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = bus.MemReady;
        pc_write_s   = bus.MemReady;
      end
      S_DECODE: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEMADR: begin
        alu_src_b_s   = 2'b01;
        imm_src_s     = 2'b10;
        alu_control_s = bus.Funct[3] ? 2'b00 : 2'b01;
      end
      S_MEMREAD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        pc_write_s   = (bus.Rd == 4'd15);
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        reg_src_s   = 2'b10;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: alu_control_s = dp_ctrl_s;
      S_EXECUTEI: begin
        alu_src_b_s   = 2'b01;
        imm_src_s     = 2'b01;
        alu_control_s = dp_ctrl_s;
      end
      S_ALUWB: begin
        reg_write_s = dp_ok_s && !dp_cmp_s;
        pc_write_s  = dp_ok_s && !dp_cmp_s && (bus.Rd == 4'd15);
      end
      S_BRANCH: begin
        reg_src_s    = 2'b01;
        alu_src_b_s  = 2'b01;
        imm_src_s    = 2'b11;
        result_src_s = 2'b10;
        pc_write_s   = 1'b1;
      end
`ifdef CTRL_BL_EN
      S_LINK: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b11;
        result_src_s = 2'b10;
        reg_write_s  = 1'b1;
        link_write_s = 1'b1;
      end
`endif
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
    if (!nReset) begin
      pc_write_s   = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      mem_write_s  = 1'b0;
      link_write_s = 1'b0;
    end else begin
      link_write_s = link_write_s;
    end
  end

  assign bus.PCWrite    = pc_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.LinkWrite  = link_write_s;
  assign bus.AdrSrc     = adr_src_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ImmSrc     = imm_src_s;
  assign bus.RegSrc     = reg_src_s;
  assign bus.ALUControl = alu_control_s;
  assign bus.State      = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle ARM-subset datapath. It sequences fetch, decode, execute, memory and writeback for data-processing, LDR/STR and branch instructions.
- Drives all datapath mux selects and write strobes, including ImmSrc for the immediate-extend unit (01 data-proc, 10 LDR/STR, 11 branch).
- Holds the NZCV flags register and evaluates condition codes.
- Stalls on a memory-ready handshake.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- CLK  input  1  clock, rising edge.
- nReset  input  1  synchronous, active-low reset.
- Cond  input  4  Instr[31:28].
- Op  input  2  Instr[27:26].
- Funct  input  6  Instr[25:20]; bit5=I, bits4:1=cmd, bit0=S (L for memory ops; bit3=U for memory ops; bit4=L-link for branch).
- Rd  input  4  Instr[15:12].
- ALUFlags  input  4  {N,Z,C,V} from the ALU this cycle.
- MemReady  input  1  memory has completed the current read/write.
- PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  write strobes.
- AdrSrc  output  1  0=PC, 1=ALUOut.
- ALUSrcA  output  1  0=Rn, 1=PC.
- ALUSrcB  output  2  00=Rm, 01=ExtImm, 10=const 4, 11=const 0.
- ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALUResult.
- ImmSrc  output  2  extend-unit select.
- RegSrc  output  2  bit0: read R15 as Rn; bit1: read Rd as Rm (STR).
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- LinkWrite  output  1  force write address to R14.
- State  output  4  current state (debug).

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, LINK=10.
- State and Flags are registered. All outputs are a combinational function of State, instruction fields and Flags.
- Unlisted outputs are 0 in every state.
- Reset:
  - While nReset=0: all strobes forced 0. On the next edge, State=FETCH and Flags=0000.
  - Mid-instruction reset abandons the instruction with no further writes.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ADD.
  - CondEx=0 -> FETCH.
  - Else Op=01 -> MEMADR; Op=00 with I=0 -> EXECUTER; Op=00 with I=1 -> EXECUTEI; Op=10 -> BRANCH (or LINK, see Optional Feature); Op=11 -> FETCH with no writes.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl ADD if U=1 else SUB.
  - L=1 -> MEMREAD; L=0 -> MEMWRITE.
- MEMREAD: AdrSrc=1. Wait for MemReady, then go to MEMWB.
- MEMWB:
  - ResultSrc=01, RegWrite=1.
  - PCWrite=1 if Rd=15.
  - Then FETCH.
- MEMWRITE:
  - AdrSrc=1, RegSrc[1]=1, MemWrite=1, held until MemReady=1, then FETCH.
  - Exactly one cycle has MemWrite=1 together with MemReady=1.
- EXECUTER / EXECUTEI:
  - ALUSrcA=0. ALUSrcB=00 (EXECUTER) or 01 with ImmSrc=01 (EXECUTEI).
  - ALUControl decode from cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB). Any other cmd is an unsupported cmd: ADD with no writes.
  - Flags update at the edge leaving this state when S=1, or always for CMP:
    - N and Z are always loaded.
    - C and V are loaded only for ADD/SUB/CMP; AND/ORR keep C and V.
  - Next state: ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegWrite=1 except for CMP or an unsupported cmd.
  - PCWrite=RegWrite when Rd=15.
  - Then FETCH.
- BRANCH:
  - RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=11, ADD, ResultSrc=10, PCWrite=1.
  - Then FETCH.
- CondEx uses the registered Flags, never ALUFlags. Codes:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 is never taken (0).
- An illegal state (11–15) returns to FETCH on the next edge with no strobes.

Optional Feature:
- Macro CTRL_BL_EN.
- Defined:
  - Op=10 with Funct[4]=1 and CondEx=1 goes DECODE -> LINK -> BRANCH.
  - LINK: ALUSrcA=1, ALUSrcB=11, ADD, ResultSrc=10, RegWrite=1, LinkWrite=1, so R14 receives the already-incremented PC.
- Undefined: BL is executed as B, LINK is unreachable, and LinkWrite is tied to 0.

Test Plan:
- Reset: hold nReset=0 for 2 cycles with MemReady=1 -> State=0, all strobes 0, Flags=0000.
- Memory stall: ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000, Rd=1) with MemReady=0 for 3 cycles then 1 -> FETCH held 4 cycles, IRWrite/PCWrite pulse once; sequence FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 in ALUWB.
- Flags and condition: CMP (Funct=010101) with ALUFlags=0100 -> Flags=0100; following BEQ (Cond=0000, Op=10) -> BRANCH, PCWrite=1, ImmSrc=11. BNE (Cond=0001) -> DECODE then FETCH with no writes.
- Load to PC: LDR Rd=15 (Op=01, Funct=011001), MemReady=1 -> MEMADR (ImmSrc=10, ADD), MEMREAD, MEMWB with RegWrite=1 and PCWrite=1.
- Store and mid-op reset:
  - STR with U=0 -> MEMADR with ALUControl=01, then MEMWRITE with RegSrc=10.
  - MemReady=0 for 2 cycles -> MemWrite held.
  - nReset=0 in the second cycle -> MemWrite=0 immediately, then State=FETCH.
- CTRL_BL_EN: BL (Funct=010000), Cond=1110 -> LINK with RegWrite=1 and LinkWrite=1, then BRANCH. With the macro undefined -> DECODE goes directly to BRANCH, LinkWrite=0 throughout.
